// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-latched data.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 1..7.
module seg7_scan (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ScanIn,
    input  logic [31:0] Value,
    input  logic [7:0]  DpMask,
    input  logic        Blank,
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp
);

    logic        scan_prev;
    logic [2:0]  digit_sel;
    logic [31:0] val_reg;
    logic [7:0]  dp_reg;

    logic        tick;
    logic        wrap;
    logic [3:0]  nibble;
    logic        lit;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = ScanIn & ~scan_prev;
    assign wrap = tick & (digit_sel == 3'd7);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            scan_prev <= 1'b0;
        end else begin
            scan_prev <= ScanIn;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            digit_sel <= 3'd0;
        end else if (tick) begin
            digit_sel <= digit_sel + 3'd1;
        end
    end

    // Display data is captured only at frame start so a frame never tears.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            val_reg <= 32'd0;
            dp_reg  <= 8'd0;
        end else if (wrap) begin
            val_reg <= Value;
            dp_reg  <= DpMask;
        end
    end

    assign nibble = val_reg[4*digit_sel +: 4];

`ifdef SEG7_LZB_EN
    logic [7:0] zero_above;

    assign zero_above[0] = 1'b0;

    genvar k;
    for (k = 1; k < 8; k++) begin : g_lzb
        assign zero_above[k] = ~|val_reg[31:4*k];
    end

    assign lit = ~zero_above[digit_sel];
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!Blank && lit) begin
            an_d  = ~(8'h01 << digit_sel);
            seg_d = hex_to_seg(nibble);
            dp_d  = ~dp_reg[digit_sel];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            An  <= 8'hFF;
            Seg <= 7'h7F;
            Dp  <= 1'b1;
        end else begin
            An  <= an_d;
            Seg <= seg_d;
            Dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized scoreboard bench for seg7_scan against a digit/frame model.
// Expected outputs are queued per cycle and checked by a separate monitor.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_in;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic        blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan dut (
        .Clk    (clk),
        .Rst    (rst),
        .ScanIn (scan_in),
        .Value  (value),
        .DpMask (dp_mask),
        .Blank  (blank),
        .An     (an),
        .Seg    (seg),
        .Dp     (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam exp_t DARK = '{8'hFF, 7'h7F, 1'b1};

    logic [6:0] font [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          m_digit;
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic        m_prev;

    int   scan_cnt = 0;
    logic scan_lvl = 1'b0;

    function automatic exp_t model_out(input logic blk);
        exp_t e;
        bit   lit;
        int   idx;
        e   = DARK;
        lit = 1'b1;
        idx = int'((m_val >> (4 * m_digit)) & 32'hF);
`ifdef SEG7_LZB_EN
        if (m_digit > 0 && (m_val >> (4 * m_digit)) == 32'd0) lit = 1'b0;
`endif
        if (!blk && lit) begin
            e.an  = 8'hFF ^ (8'h01 << m_digit);
            e.seg = font[idx];
            e.dp  = ~m_dp[m_digit];
        end
        return e;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                     name, $time, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        end
    endtask

    task automatic model_reset();
        m_digit = 0;
        m_val   = 32'd0;
        m_dp    = 8'd0;
        m_prev  = 1'b0;
    endtask

    // One clock of stimulus; inputs change on the falling edge.
    task automatic step(input logic s, input logic [31:0] v,
                        input logic [7:0] d, input logic b);
        @(negedge clk);
        rst     = 1'b1;
        scan_in = s;
        value   = v;
        dp_mask = d;
        blank   = b;
        q.push_back(model_out(b));
        if (s && !m_prev) begin
            if (m_digit == 7) begin
                m_val = v;
                m_dp  = d;
            end
            m_digit = (m_digit + 1) % 8;
        end
        m_prev = s;
    endtask

    task automatic do_reset(input int hold);
        exp_t g;
        @(negedge clk);
        rst = 1'b0;
        #1;
        g = '{an, seg, dp};
        check("async_reset", g, DARK);
        model_reset();
        q.push_back(DARK);
        repeat (hold) begin
            @(negedge clk);
            q.push_back(DARK);
        end
    endtask

    function automatic logic next_scan();
        if (scan_cnt <= 0) begin
            scan_lvl = ~scan_lvl;
            scan_cnt = $urandom_range(1, 5);
        end
        scan_cnt--;
        return scan_lvl;
    endfunction

    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = '{an, seg, dp};
                check("scan_out", g, e);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] v;
        logic [7:0]  d;
        logic        b;
        int          guard;

        rst     = 1'b0;
        scan_in = 1'b0;
        value   = 32'd0;
        dp_mask = 8'd0;
        blank   = 1'b0;
        model_reset();
        do_reset(3);

        repeat (400) step(next_scan(), 32'h1234ABCD, 8'h01, 1'b0);

        v = 32'h1234ABCD;
        d = 8'h01;
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) v = $urandom;
            if ($urandom_range(0, 15) == 0) d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = ~b;
            if ($urandom_range(0, 199) == 0) begin
                scan_lvl = 1'b1;
                scan_cnt = 100;
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(0, 3));
                scan_lvl = 1'b0;
                scan_cnt = 0;
            end else begin
                step(next_scan(), v, d, b);
            end
        end

        repeat (300) step(next_scan(), 32'h000000A5, 8'hFF, 1'b0);
        repeat (300) step(next_scan(), 32'h00000000, 8'h00, 1'b0);

        guard = 0;
        while (m_digit != 5 && guard < 200) begin
            step(next_scan(), 32'hFFFFFFFF, 8'h80, 1'b0);
            guard++;
        end
        vectors++;
        if (m_digit != 5) begin
            miscompares++;
            $display("FAIL reach_digit5 got %0d want 5", m_digit);
        end
        do_reset(2);
        scan_lvl = 1'b0;
        scan_cnt = 0;
        repeat (300) step(next_scan(), 32'h9876FEDC, 8'h5A, 1'b0);

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain got %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
